// File: rtl/reg_cmd_ctrl.sv
// rtl/reg_cmd_ctrl.sv - command decoder between the UART RX byte stream and the register file
// Parses WR (opcode,addr,data) and RD (opcode,addr) frames; read data is returned to the TX FIFO.
module reg_cmd_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] CMD_WR     = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] CMD_RD     = 8'hBB,
  parameter int                    RD_TIMEOUT = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_Data,
  input  logic                  RX_D_VLD,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  input  logic                  FIFO_FULL,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [DATA_WIDTH-1:0] TX_P_Data,
  output logic                  TX_D_VLD,
  output logic                  Busy,
  output logic                  CMD_ERR
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_WAIT = 3'd4,
    TX_SEND = 3'd5
  } state_t;

  // Counter holds cycles already spent in RD_WAIT; the last allowed cycle is RD_TIMEOUT-1.
  localparam logic [3:0] TO_LAST = 4'(RD_TIMEOUT - 1);

  state_t                  state, state_n;
  logic [3:0]              cnt, cnt_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   wdata_n, tx_data_n;
  logic                    wr_en_n, rd_en_n, tx_vld_n, err_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      Address   <= '0;
      WrData    <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_P_Data <= '0;
      TX_D_VLD  <= 1'b0;
      Busy      <= 1'b0;
      CMD_ERR   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      Address   <= addr_n;
      WrData    <= wdata_n;
      WrEn      <= wr_en_n;
      RdEn      <= rd_en_n;
      TX_P_Data <= tx_data_n;
      TX_D_VLD  <= tx_vld_n;
      Busy      <= (state_n != IDLE);
      CMD_ERR   <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    addr_n    = Address;
    wdata_n   = WrData;
    tx_data_n = TX_P_Data;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    tx_vld_n  = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_Data == CMD_WR)      state_n = WR_ADDR;
          else if (RX_P_Data == CMD_RD) state_n = RD_ADDR;
          else                          err_n   = 1'b1;
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_n  = RX_P_Data[ADDR_WIDTH-1:0];
          state_n = WR_DATA;
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wdata_n = RX_P_Data;
          wr_en_n = 1'b1;
          state_n = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_n  = RX_P_Data[ADDR_WIDTH-1:0];
          rd_en_n = 1'b1;
          cnt_n   = '0;
          state_n = RD_WAIT;
        end
      end
      RD_WAIT: begin
        // Stray RX bytes are dropped; read data still wins over the timeout.
        err_n = RX_D_VLD;
        if (RdData_Valid) begin
          tx_data_n = RdData;
          cnt_n     = '0;
          state_n   = TX_SEND;
        end else if (cnt == TO_LAST) begin
          err_n   = 1'b1;
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end
      TX_SEND: begin
        err_n = RX_D_VLD;
        if (!FIFO_FULL) begin
          tx_vld_n = 1'b1;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// tb/tb_reg_cmd_ctrl.sv - directed self-checking bench for reg_cmd_ctrl
module tb_reg_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_Data;
  logic       RX_D_VLD;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic       FIFO_FULL;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic       WrEn;
  logic       RdEn;
  logic [7:0] TX_P_Data;
  logic       TX_D_VLD;
  logic       Busy;
  logic       CMD_ERR;

  int n_pass = 0;
  int n_total = 0;

  reg_cmd_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .FIFO_FULL(FIFO_FULL),
    .Address(Address), .WrData(WrData), .WrEn(WrEn), .RdEn(RdEn),
    .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD), .Busy(Busy), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_Data = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  initial begin
    RST = 1'b0; RX_P_Data = '0; RX_D_VLD = 1'b0;
    RdData = '0; RdData_Valid = 1'b0; FIFO_FULL = 1'b0;
    tick(); tick();
    chk("reset_outputs", {Address, WrData, WrEn, RdEn, TX_D_VLD, Busy}, 16'h0000);
    chk("reset_err_tx", {CMD_ERR, TX_P_Data}, 16'h0000);
    RST = 1'b1;
    tick();

    // 1: write AA,F5,3C -> address upper bits dropped
    send(8'hAA);
    chk("wr_busy_after_op", Busy, 1);
    send(8'hF5);
    chk("wr_addr_latched", Address, 4'h5);
    chk("wr_no_early_en", WrEn, 0);
    send(8'h3C);
    chk("wr_en_pulse", {WrEn, RdEn, Address, WrData}, {1'b1, 1'b0, 4'h5, 8'h3C});
    tick();
    chk("wr_en_drop", {WrEn, RdEn, Busy}, 3'b000);
    chk("wr_hold", {Address, WrData}, {4'h5, 8'h3C});

    // 2: read BB,02, model returns 0x81 the cycle after RdEn
    send(8'hBB);
    send(8'h02);
    chk("rd_en_pulse", {RdEn, WrEn, Address}, {1'b1, 1'b0, 4'h2});
    RdData = 8'h81; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    chk("rd_en_drop", {RdEn, TX_D_VLD, Busy}, 3'b001);
    tick();
    chk("rd_tx_send", {TX_D_VLD, TX_P_Data}, {1'b1, 8'h81});
    tick();
    chk("rd_tx_drop", {TX_D_VLD, TX_P_Data, Busy}, {1'b0, 8'h81, 1'b0});

    // 3: read with FIFO full for 20 cycles
    FIFO_FULL = 1'b1;
    send(8'hBB);
    send(8'h0C);
    RdData = 8'h4E; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0; RdData = 8'h00;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("full_hold", {TX_D_VLD, TX_P_Data, Busy}, {1'b0, 8'h4E, 1'b1});
    end
    FIFO_FULL = 1'b0;
    tick();
    chk("full_release", {TX_D_VLD, TX_P_Data}, {1'b1, 8'h4E});
    tick();
    chk("full_done", {TX_D_VLD, Busy}, 2'b00);

    // 4: read timeout after 8 cycles in RD_WAIT
    send(8'hBB);
    send(8'h07);
    chk("to_rd_en", {RdEn, Address}, {1'b1, 4'h7});
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_waiting", {CMD_ERR, TX_D_VLD, Busy}, 3'b001);
    end
    tick();
    chk("to_err_pulse", {CMD_ERR, TX_D_VLD, Busy}, 3'b100);
    tick();
    chk("to_err_drop", {CMD_ERR, TX_D_VLD}, 2'b00);
    send(8'hAA);
    send(8'h07);
    send(8'h11);
    chk("to_recover_wr", {WrEn, Address, WrData, CMD_ERR}, {1'b1, 4'h7, 8'h11, 1'b0});
    tick();

    // 5: unknown opcode in IDLE, stray byte during TX_SEND
    send(8'h55);
    chk("bad_op_err", {CMD_ERR, Busy}, 2'b10);
    tick();
    chk("bad_op_drop", {CMD_ERR, Busy}, 2'b00);
    FIFO_FULL = 1'b1;
    send(8'hBB);
    send(8'h09);
    RdData = 8'hC7; RdData_Valid = 1'b1;
    tick();
    RdData_Valid = 1'b0;
    send(8'h12);
    chk("stray_err", {CMD_ERR, Busy, TX_D_VLD}, 3'b110);
    FIFO_FULL = 1'b0;
    tick();
    chk("stray_still_sent", {TX_D_VLD, TX_P_Data, CMD_ERR}, {1'b1, 8'hC7, 1'b0});
    tick();

    // 6: reset mid-frame aborts the write
    send(8'hAA);
    send(8'h03);
    RST = 1'b0;
    #1;
    chk("rst_async", {Busy, Address}, 5'h00);
    tick(); tick();
    chk("rst_mid_frame", {WrEn, RdEn, Busy, WrData}, 11'h000);
    RST = 1'b1;
    tick();
    send(8'h99);
    chk("rst_then_unknown", {CMD_ERR, WrEn, Busy}, 3'b100);
    tick();
    chk("rst_no_late_wr", {WrEn, CMD_ERR}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
